// File: rtl/axi_slice_dc_pwr_pkg.sv
// Shared types and helpers for the dual-clock AXI slice power sequencer.
// Optional drain timeout is enabled with AXI_SLICE_DC_PWR_TIMEOUT_EN.
package axi_slice_dc_pwr_pkg;

   typedef enum logic [2:0] {
      ACTIVE  = 3'd0,
      DRAIN   = 3'd1,
      ISOLATE = 3'd2,
      GATED   = 3'd3,
      WAKE    = 3'd4
   } pwr_state_e;

   // The shared cycle counter must reach the largest of the dwell/timeout lengths.
   function automatic int cyc_cnt_width(input int iso, input int wake, input int tmo);
      int m;
      m = iso;
      if (wake > m) m = wake;
      if (tmo > m) m = tmo;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/axi_slice_dc_txn_cnt.sv
// Saturating up/down outstanding-transaction counter; decrement at zero is dropped.
module axi_slice_dc_txn_cnt #(
   parameter int WIDTH = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic dec_i,
   input  logic clr_i,
   output logic zero_o,
   output logic max_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign zero_o = (cnt_q == '0);
   assign max_o  = &cnt_q;

   // NOTE: every path below starts from the held value, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i) begin
         if (!max_o) cnt_d = cnt_q + WIDTH'(1);
      end else if (dec_i && !inc_i) begin
         if (!zero_o) cnt_d = cnt_q - WIDTH'(1);
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec_i && !inc_i && !clr_i && zero_o));

endmodule

// File: rtl/axi_slice_dc_pwr_ctrl.sv
// Power/isolation sequencer for the master side of the dual-clock AXI slice.
// Define AXI_SLICE_DC_PWR_TIMEOUT_EN to add the drain timeout and timeout_o.
module axi_slice_dc_pwr_ctrl
   import axi_slice_dc_pwr_pkg::*;
#(
   parameter int CNT_WIDTH      = 8,
   parameter int ISO_CYCLES     = 4,
   parameter int WAKE_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       pwr_down_req_i,
   input  logic       pwr_up_req_i,
   input  logic       incoming_req_i,
   input  logic       aw_valid_i,
   input  logic       aw_ready_i,
   input  logic       w_valid_i,
   input  logic       w_ready_i,
   input  logic       w_last_i,
   input  logic       ar_valid_i,
   input  logic       ar_ready_i,
   input  logic       r_valid_i,
   input  logic       r_ready_i,
   input  logic       r_last_i,
   input  logic       b_valid_i,
   input  logic       b_ready_i,
   output logic       clock_down_o,
   output logic       isolate_o,
   output logic       clk_en_o,
   output logic       pwr_ack_o,
   output logic [2:0] state_o,
   output logic       busy_o
`ifdef AXI_SLICE_DC_PWR_TIMEOUT_EN
   ,
   output logic       timeout_o
`endif
);

   localparam int CW  = cyc_cnt_width(ISO_CYCLES, WAKE_CYCLES, TIMEOUT_CYCLES);
   localparam int WPW = CNT_WIDTH + 1;
   localparam logic signed [WPW-1:0] WP_MAX = {1'b0, {CNT_WIDTH{1'b1}}};
   localparam logic signed [WPW-1:0] WP_MIN = {1'b1, {CNT_WIDTH{1'b0}}};

   pwr_state_e              state_q, state_d;
   logic [CW-1:0]           cyc_q, cyc_d;
   logic signed [WPW-1:0]   wp_q, wp_d;
   logic                    clock_down_q, isolate_q, clk_en_q, pwr_ack_q;
   logic                    tmo_fire;
   logic                    wr_zero, wr_max, rd_zero, rd_max, drained;

   // Counters freeze while the slice clock is gated.
   logic hold;
   assign hold = (state_q == GATED);

   logic wr_inc, wr_dec, rd_inc, rd_dec, wp_dec;
   assign wr_inc = aw_valid_i & aw_ready_i & ~hold;
   assign wr_dec = b_valid_i & b_ready_i & ~hold;
   assign rd_inc = ar_valid_i & ar_ready_i & ~hold;
   assign rd_dec = r_valid_i & r_ready_i & r_last_i & ~hold;
   assign wp_dec = w_valid_i & w_ready_i & w_last_i & ~hold;

   axi_slice_dc_txn_cnt #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk_i (clk_i), .rst_ni(rst_ni), .inc_i(wr_inc), .dec_i(wr_dec),
      .clr_i (tmo_fire), .zero_o(wr_zero), .max_o(wr_max)
   );

   axi_slice_dc_txn_cnt #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk_i (clk_i), .rst_ni(rst_ni), .inc_i(rd_inc), .dec_i(rd_dec),
      .clr_i (tmo_fire), .zero_o(rd_zero), .max_o(rd_max)
   );

   // W data may arrive before its AW, so the write-pairing count goes negative.
   always_comb begin
      wp_d = wp_q;
      if (tmo_fire) begin
         wp_d = '0;
      end else if (wr_inc && !wp_dec) begin
         if (wp_q != WP_MAX) wp_d = wp_q + WPW'(1);
      end else if (wp_dec && !wr_inc) begin
         if (wp_q != WP_MIN) wp_d = wp_q - WPW'(1);
      end
   end

   assign drained = wr_zero & rd_zero & (wp_q == '0);

   always_comb begin
      state_d  = state_q;
      tmo_fire = 1'b0;
      unique case (state_q)
         ACTIVE:  if (pwr_down_req_i && !pwr_up_req_i) state_d = DRAIN;
         DRAIN: begin
            if (pwr_up_req_i)  state_d = ACTIVE;
            else if (drained)  state_d = ISOLATE;
`ifdef AXI_SLICE_DC_PWR_TIMEOUT_EN
            else if (cyc_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d  = ISOLATE;
               tmo_fire = 1'b1;
            end
`endif
         end
         ISOLATE: if (cyc_q == CW'(ISO_CYCLES - 1)) state_d = GATED;
         GATED:   if (incoming_req_i || pwr_up_req_i) state_d = WAKE;
         WAKE:    if (cyc_q == CW'(WAKE_CYCLES - 1)) state_d = ACTIVE;
         default: state_d = ACTIVE;
      endcase
   end

   assign cyc_d = (state_d != state_q) ? '0 : cyc_q + CW'(1);

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ACTIVE;
         cyc_q        <= '0;
         wp_q         <= '0;
         clock_down_q <= 1'b0;
         isolate_q    <= 1'b0;
         clk_en_q     <= 1'b1;
         pwr_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         wp_q         <= wp_d;
         clock_down_q <= (state_d != ACTIVE) | wr_max | rd_max;
         isolate_q    <= (state_d == ISOLATE) | (state_d == GATED) | (state_d == WAKE);
         clk_en_q     <= (state_d != GATED);
         pwr_ack_q    <= (state_d == GATED);
      end
   end

`ifdef AXI_SLICE_DC_PWR_TIMEOUT_EN
   logic timeout_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) timeout_q <= 1'b0;
      else         timeout_q <= timeout_q | tmo_fire;
   end
   assign timeout_o = timeout_q;
`endif

   assign clock_down_o = clock_down_q;
   assign isolate_o    = isolate_q;
   assign clk_en_o     = clk_en_q;
   assign pwr_ack_o    = pwr_ack_q;
   assign state_o      = state_q;
   assign busy_o       = ~drained;

endmodule

// File: tb/tb_axi_slice_dc_pwr_ctrl.sv
// Directed self-checking bench for axi_slice_dc_pwr_ctrl (default parameters).
module tb_axi_slice_dc_pwr_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       pwr_down_req_i, pwr_up_req_i, incoming_req_i;
   logic       aw_valid_i, aw_ready_i, w_valid_i, w_ready_i, w_last_i;
   logic       ar_valid_i, ar_ready_i, r_valid_i, r_ready_i, r_last_i;
   logic       b_valid_i, b_ready_i;
   logic       clock_down_o, isolate_o, clk_en_o, pwr_ack_o, busy_o;
   logic [2:0] state_o;
`ifdef AXI_SLICE_DC_PWR_TIMEOUT_EN
   logic       timeout_o;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   axi_slice_dc_pwr_ctrl #(
      .CNT_WIDTH(8), .ISO_CYCLES(4), .WAKE_CYCLES(8)
`ifdef AXI_SLICE_DC_PWR_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .pwr_down_req_i(pwr_down_req_i), .pwr_up_req_i(pwr_up_req_i),
      .incoming_req_i(incoming_req_i),
      .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i),
      .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i),
      .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i),
      .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
      .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
      .clock_down_o(clock_down_o), .isolate_o(isolate_o), .clk_en_o(clk_en_o),
      .pwr_ack_o(pwr_ack_o), .state_o(state_o), .busy_o(busy_o)
`ifdef AXI_SLICE_DC_PWR_TIMEOUT_EN
      , .timeout_o(timeout_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_aw(input logic v);
      aw_valid_i = v; aw_ready_i = v;
   endtask

   task automatic set_w_last(input logic v);
      w_valid_i = v; w_ready_i = v; w_last_i = v;
   endtask

   task automatic set_ar(input logic v);
      ar_valid_i = v; ar_ready_i = v;
   endtask

   task automatic set_r_last(input logic v);
      r_valid_i = v; r_ready_i = v; r_last_i = v;
   endtask

   task automatic set_b(input logic v);
      b_valid_i = v; b_ready_i = v;
   endtask

   // From GATED: one-cycle power-up pulse, then the full WAKE dwell.
   task automatic wake_to_active();
      pwr_up_req_i = 1'b1;
      step();
      pwr_up_req_i = 1'b0;
      steps(8);
   endtask

   initial begin
      rst_ni = 1'b0;
      pwr_down_req_i = 1'b0; pwr_up_req_i = 1'b0; incoming_req_i = 1'b0;
      set_aw(1'b0); set_w_last(1'b0); set_ar(1'b0); set_r_last(1'b0); set_b(1'b0);
      steps(2);
      check("rst_state", 32'(state_o), 0);
      check("rst_clock_down", 32'(clock_down_o), 0);
      check("rst_isolate", 32'(isolate_o), 0);
      check("rst_clk_en", 32'(clk_en_o), 1);
      check("rst_ack", 32'(pwr_ack_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      rst_ni = 1'b1;
      step();

      // Idle power-down: DRAIN at 1, ISOLATE at 2, GATED at 6.
      pwr_down_req_i = 1'b1;
      step();
      check("t1_drain", 32'(state_o), 1);
      check("t1_drain_cd", 32'(clock_down_o), 1);
      check("t1_drain_iso", 32'(isolate_o), 0);
      step();
      check("t1_isolate", 32'(state_o), 2);
      check("t1_isolate_iso", 32'(isolate_o), 1);
      check("t1_isolate_clken", 32'(clk_en_o), 1);
      steps(3);
      check("t1_iso_last", 32'(state_o), 2);
      check("t1_iso_last_ack", 32'(pwr_ack_o), 0);
      step();
      check("t1_gated", 32'(state_o), 3);
      check("t1_gated_ack", 32'(pwr_ack_o), 1);
      check("t1_gated_clken", 32'(clk_en_o), 0);
      pwr_down_req_i = 1'b0;
      steps(2);
      check("t1_gated_hold", 32'(state_o), 3);

      // Wake on a single-cycle incoming request.
      incoming_req_i = 1'b1;
      step();
      incoming_req_i = 1'b0;
      check("t3_wake", 32'(state_o), 4);
      check("t3_wake_clken", 32'(clk_en_o), 1);
      check("t3_wake_iso", 32'(isolate_o), 1);
      check("t3_wake_cd", 32'(clock_down_o), 1);
      check("t3_wake_ack", 32'(pwr_ack_o), 0);
      steps(7);
      check("t3_wake_last", 32'(state_o), 4);
      check("t3_wake_last_iso", 32'(isolate_o), 1);
      step();
      check("t3_active", 32'(state_o), 0);
      check("t3_active_iso", 32'(isolate_o), 0);
      check("t3_active_cd", 32'(clock_down_o), 0);

      // Three writes outstanding hold DRAIN until all B responses return.
      set_aw(1'b1); set_w_last(1'b1);
      steps(3);
      set_aw(1'b0); set_w_last(1'b0);
      check("t2_busy", 32'(busy_o), 1);
      pwr_down_req_i = 1'b1;
      step();
      check("t2_drain", 32'(state_o), 1);
      steps(3);
      check("t2_drain_hold", 32'(state_o), 1);
      set_b(1'b1);
      steps(2);
      check("t2_two_b_busy", 32'(busy_o), 1);
      step();
      set_b(1'b0);
      check("t2_idle", 32'(busy_o), 0);
      step();
      check("t2_isolate", 32'(state_o), 2);
      pwr_down_req_i = 1'b0;
      steps(4);
      check("t2_gated", 32'(state_o), 3);
      wake_to_active();
      check("t2_active", 32'(state_o), 0);

      // W-last ahead of its AW: negative pairing count holds DRAIN.
      set_w_last(1'b1);
      step();
      set_w_last(1'b0);
      check("t4_busy_wp", 32'(busy_o), 1);
      pwr_down_req_i = 1'b1;
      step();
      check("t4_drain", 32'(state_o), 1);
      steps(2);
      check("t4_drain_hold", 32'(state_o), 1);
      set_aw(1'b1);
      step();
      set_aw(1'b0);
      check("t4_busy_wr", 32'(busy_o), 1);
      step();
      check("t4_drain_wait_b", 32'(state_o), 1);
      set_b(1'b1);
      step();
      set_b(1'b0);
      check("t4_idle", 32'(busy_o), 0);
      step();
      check("t4_isolate", 32'(state_o), 2);
      pwr_down_req_i = 1'b0;
      steps(4);
      check("t4_gated", 32'(state_o), 3);
      wake_to_active();
      check("t4_active", 32'(state_o), 0);

      // Abort DRAIN with two reads outstanding; AR and R-last together cancel.
      set_ar(1'b1);
      steps(2);
      set_ar(1'b0);
      pwr_down_req_i = 1'b1;
      step();
      check("t5_drain", 32'(state_o), 1);
      check("t5_drain_cd", 32'(clock_down_o), 1);
      set_ar(1'b1); set_r_last(1'b1);
      step();
      set_ar(1'b0); set_r_last(1'b0);
      check("t5_drain_hold", 32'(state_o), 1);
      pwr_up_req_i = 1'b1;
      step();
      check("t5_abort", 32'(state_o), 0);
      check("t5_abort_cd", 32'(clock_down_o), 0);
      pwr_down_req_i = 1'b0; pwr_up_req_i = 1'b0;
      set_r_last(1'b1);
      step();
      check("t5_rd_one_left", 32'(busy_o), 1);
      step();
      set_r_last(1'b0);
      check("t5_rd_empty", 32'(busy_o), 0);

      // Read counter saturation throttles new requests in ACTIVE.
      set_ar(1'b1);
      steps(255);
      check("thr_below", 32'(clock_down_o), 0);
      step();
      set_ar(1'b0);
      check("thr_at_max", 32'(clock_down_o), 1);
      check("thr_state", 32'(state_o), 0);
      step();
      check("thr_hold", 32'(clock_down_o), 1);
      set_r_last(1'b1);
      steps(254);
      check("thr_sat_busy", 32'(busy_o), 1);
      step();
      set_r_last(1'b0);
      check("thr_sat_empty", 32'(busy_o), 0);
      step();
      check("thr_release", 32'(clock_down_o), 0);

`ifdef AXI_SLICE_DC_PWR_TIMEOUT_EN
      // B never returns: timeout forces ISOLATE after 16 DRAIN cycles.
      set_aw(1'b1);
      step();
      set_aw(1'b0);
      pwr_down_req_i = 1'b1;
      step();
      check("tmo_drain", 32'(state_o), 1);
      check("tmo_low", 32'(timeout_o), 0);
      steps(15);
      check("tmo_drain_last", 32'(state_o), 1);
      step();
      check("tmo_isolate", 32'(state_o), 2);
      check("tmo_flag", 32'(timeout_o), 1);
      check("tmo_cleared", 32'(busy_o), 0);
      pwr_down_req_i = 1'b0;
      steps(4);
      check("tmo_gated", 32'(state_o), 3);
      wake_to_active();
      check("tmo_active", 32'(state_o), 0);
      check("tmo_sticky", 32'(timeout_o), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
